// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage RV64I pipeline: shadows the EX/MEM/WB destination
// writes, raises stall/bubble/flush, and sequences multi-cycle EX ops with an occupancy counter.

module hazard_scoreboard_checker (
  input logic clk,
  input logic rst,
  input logic ex_busy,
  input logic ex_redirect
);

  // A redirect cannot be resolved while a long op still owns EX.
  a_no_redirect_when_busy : assert property (
    @(posedge clk) disable iff (rst) ex_busy |-> !ex_redirect
  );

endmodule

module hazard_scoreboard #(
  parameter int LONG_LAT       = 4,
  parameter bit RF_WRITE_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_en,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_en,
  input  logic [4:0] id_rd,
  input  logic       id_rd_wen,
  input  logic       id_is_load,
  input  logic       id_is_long,
  input  logic       ex_redirect,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       ex_busy,
  output logic [1:0] inflight
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
  } slot_t;

  localparam logic [3:0] LONG_INIT = 4'(LONG_LAT - 1);

  slot_t      ex_slot, mem_slot, wb_slot;
  slot_t      ex_next, mem_next, wb_next;
  logic [3:0] cnt, cnt_next;
  logic [1:0] inflight_next;
  logic       busy, redirect, hit_ex, hit_wb, load_use, wb_stall, dep_stall;

  // A slot only matters if it will really write a non-x0 register.
  function automatic logic writes(input slot_t s);
    return s.valid & s.wen & (s.rd != 5'd0);
  endfunction

  function automatic logic src_hit(input slot_t s, input logic [4:0] rs, input logic en);
    return en & writes(s) & (rs == s.rd);
  endfunction

  assign busy      = (cnt != 4'd0);
  assign redirect  = ex_redirect & ~busy;
  assign hit_ex    = id_valid & (src_hit(ex_slot, id_rs1, id_rs1_en) |
                                 src_hit(ex_slot, id_rs2, id_rs2_en));
  assign hit_wb    = id_valid & (src_hit(wb_slot, id_rs1, id_rs1_en) |
                                 src_hit(wb_slot, id_rs2, id_rs2_en));
  assign load_use  = hit_ex & ex_slot.is_load;
  assign wb_stall  = RF_WRITE_FIRST ? 1'b0 : hit_wb;
  assign dep_stall = load_use | wb_stall;

  // Pipeline control and next shadow state; busy > redirect > dependency stall > advance.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    ex_busy   = 1'b0;
    ex_next   = ex_slot;
    mem_next  = ex_slot;
    wb_next   = mem_slot;
    cnt_next  = cnt;
    if (busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      ex_busy  = 1'b1;
      mem_next = '0;
      cnt_next = cnt - 4'd1;
    end else if (redirect) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      ex_next   = '0;
    end else if (dep_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      ex_next   = '0;
    end else begin
      if (id_valid) begin
        ex_next = {1'b1, id_rd, id_rd_wen, id_is_load};
      end else begin
        ex_next = '0;
      end
      if (id_valid & id_is_long) begin
        cnt_next = LONG_INIT;
      end else begin
        cnt_next = 4'd0;
      end
    end
  end

  assign inflight_next = 2'(writes(ex_next)) + 2'(writes(mem_next)) + 2'(writes(wb_next));

  // Shadow slots, occupancy counter and the registered in-flight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
      cnt      <= 4'd0;
      inflight <= 2'd0;
    end else begin
      ex_slot  <= ex_next;
      mem_slot <= mem_next;
      wb_slot  <= wb_next;
      cnt      <= cnt_next;
      inflight <= inflight_next;
    end
  end

  hazard_scoreboard_checker u_checker (
    .clk         (clk),
    .rst         (rst),
    .ex_busy     (ex_busy),
    .ex_redirect (ex_redirect)
  );

endmodule
